// File: rtl/krake_intercon.sv
// Bus interconnect: krake_bus master to NSLV slaves with one-hot select decode,
// registered response path, unmapped-select error. Optional watchdog: INTERCON_TIMEOUT_EN.
module krake_intercon #(
  parameter int NSLV    = 12,
  parameter int ADR_W   = 8,
  parameter int SEL_W   = 4,
  parameter int DAT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADR_W-1:0]        adr_i,
  input  logic [DAT_W-1:0]        dat_i,
  output logic [DAT_W-1:0]        dat_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic [NSLV-1:0]         slv_stb_o,
  output logic                    slv_we_o,
  output logic [ADR_W-SEL_W-1:0]  slv_adr_o,
  output logic [DAT_W-1:0]        slv_dat_o,
  input  logic [NSLV*DAT_W-1:0]   slv_dat_i,
  input  logic [NSLV-1:0]         slv_ack_i
);

  localparam int LADR_W = ADR_W - SEL_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  if (NSLV < 1 || NSLV > 2**SEL_W || SEL_W >= ADR_W || TIMEOUT < 2) begin : g_bad_cfg
    $error("krake_intercon: illegal parameter combination");
  end

  state_t             state_q, state_d;
  logic [NSLV-1:0]    stb_q,   stb_d;
  logic               we_q,    we_d;
  logic [LADR_W-1:0]  adr_q,   adr_d;
  logic [DAT_W-1:0]   wdat_q,  wdat_d;
  logic [DAT_W-1:0]   dat_q,   dat_d;
  logic               ack_q,   ack_d;
  logic               err_q,   err_d;

  // Request decode from the live master address
  logic [SEL_W-1:0]   req_sel;
  logic               req_mapped;
  logic [NSLV-1:0]    req_onehot;

  assign req_sel    = adr_i[ADR_W-1 -: SEL_W];
  assign req_mapped = (32'(req_sel) < NSLV);

  always_comb begin
    req_onehot = '0;
    for (int k = 0; k < NSLV; k++) begin
      req_onehot[k] = (32'(req_sel) == k);
    end
  end

  // Per-slave response gating; stb_q is one-hot, so at most one lane is live
  logic [NSLV-1:0]            lane_hit;
  logic [NSLV-1:0][DAT_W-1:0] lane_dat;

  for (genvar g = 0; g < NSLV; g++) begin : g_lane
    assign lane_hit[g] = stb_q[g] & slv_ack_i[g];
    assign lane_dat[g] = stb_q[g] ? slv_dat_i[g*DAT_W +: DAT_W] : '0;
  end

  logic             sel_hit;
  logic [DAT_W-1:0] sel_rdat;

  always_comb begin
    sel_hit  = |lane_hit;
    sel_rdat = '0;
    for (int k = 0; k < NSLV; k++) begin
      sel_rdat = sel_rdat | lane_dat[k];
    end
  end

`ifdef INTERCON_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_expired;

  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT));
`endif

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef INTERCON_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (stb_i) begin
          we_d   = we_i;
          adr_d  = adr_i[LADR_W-1:0];
          wdat_d = dat_i;
          if (req_mapped) begin
            stb_d   = req_onehot;
            state_d = S_ACTIVE;
`ifdef INTERCON_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d   = 1'b1;
            dat_d   = '1;
            state_d = S_RESP;
          end
        end
      end

      S_ACTIVE: begin
        if (!stb_i) begin
          // Master abort: drop the strobe silently
          stb_d   = '0;
          state_d = S_IDLE;
        end else if (sel_hit) begin
          ack_d   = 1'b1;
          dat_d   = sel_rdat;
          stb_d   = '0;
          state_d = S_RESP;
        end
`ifdef INTERCON_TIMEOUT_EN
        else if (cnt_expired) begin
          err_d   = 1'b1;
          dat_d   = '1;
          stb_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_RESP: begin
        state_d = S_HOLD;
      end

      S_HOLD: begin
        // A strobe still held from the finished transfer must not re-issue it
        if (!stb_i) state_d = S_IDLE;
      end

      default: begin
        stb_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      stb_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef INTERCON_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign slv_stb_o = stb_q;
  assign slv_we_o  = we_q;
  assign slv_adr_o = adr_q;
  assign slv_dat_o = wdat_q;

endmodule

// File: doc/krake_intercon.md
# krake_intercon

Parametrised bus interconnect between the krake_bus master and NSLV peripheral slaves (ports, clock generators, glitchers). It decodes the upper address bits into a one-hot slave strobe and registers the selected slave's read data and acknowledge back to the master. It adds an error response for unmapped selects and an optional bus-hang watchdog. It replaces the fixed 12-way hand-written decode/mux in the core top level.

## Interface
- NSLV, 12: number of slaves, 1..(2^SEL_W); slave k is mapped at select value k.
- ADR_W, 8: master address width.
- SEL_W, 4: number of upper address bits used as the slave select, adr_i[ADR_W-1:ADR_W-SEL_W].
- DAT_W, 8: data width.
- TIMEOUT, 15: watchdog limit in clk_i cycles, ≥2; only used with INTERCON_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-low.
- stb_i  in  1  master strobe; held high until ack_o or err_o.
- we_i  in  1  master write enable.
- adr_i  in  ADR_W  master address.
- dat_i  in  DAT_W  master write data.
- dat_o  out  DAT_W  read data to the master; valid while ack_o is high.
- ack_o  out  1  one-cycle transfer-complete pulse.
- err_o  out  1  one-cycle error pulse: unmapped select or timeout.
- slv_stb_o  out  NSLV  one-hot slave strobes.
- slv_we_o  out  1  latched we to all slaves.
- slv_adr_o  out  ADR_W-SEL_W  latched low address bits to all slaves.
- slv_dat_o  out  DAT_W  latched write data to all slaves.
- slv_dat_i  in  NSLV*DAT_W  slave read data; slave k occupies bits [k*DAT_W +: DAT_W].
- slv_ack_i  in  NSLV  slave acknowledges.

## Operation
- The FSM has four states: IDLE, ACTIVE, RESP, HOLD.
- IDLE:
  - On stb_i=1, latch sel, we, low address and write data, then go to ACTIVE if sel<NSLV, otherwise RESP with error.
  - Latched values drive the slv_* broadcast outputs until the next accept.
- ACTIVE:
  - slv_stb_o[sel]=1; all other strobes are 0.
  - On slv_ack_i[sel]=1, capture slv_dat_i[sel] into dat_o and go to RESP with ack.
  - Acks from unselected slaves are ignored.
- RESP:
  - Assert ack_o or err_o for exactly one cycle; slv_stb_o is all zero.
  - On error, dat_o is {DAT_W{1'b1}}.
  - Next state is HOLD.
- HOLD: wait for stb_i=0, then go to IDLE. This prevents a held strobe from re-issuing the transfer.
- Abort: stb_i=0 while in ACTIVE drops slv_stb_o on the next edge, returns to IDLE, and produces no ack_o or err_o.
- Reset:
  - rst_i=0 at any edge forces IDLE.
  - All outputs go to 0: dat_o, ack_o, err_o, slv_stb_o, slv_we_o, slv_adr_o, slv_dat_o. This includes reset mid-transfer.

## Timing
- Edge n samples stb_i=1 in IDLE; slv_stb_o[sel] rises after edge n.
- With a slave that acks combinationally, slv_ack_i is sampled at edge n+1. ack_o and dat_o are then high/valid for the cycle after edge n+1 (master latency 2 cycles).
- A registered-ack slave adds one cycle per extra wait state.
- Unmapped select: err_o is high in the cycle after edge n (latency 1).
- All outputs are registered; there are no combinational paths from the slv_* inputs to the master outputs.
- The master must hold stb_i, adr_i, we_i and dat_i stable until ack_o or err_o. The broadcast outputs are latched, so later changes have no effect.
- Back-to-back transfers need at least one cycle of stb_i=0 (HOLD→IDLE). Throughput is one transfer per 4 cycles minimum.

## Configuration
- INTERCON_TIMEOUT_EN defined:
  - A cycle counter of width $clog2(TIMEOUT+1) clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When the count reaches TIMEOUT without an ack, the block goes to RESP with error, so err_o pulses TIMEOUT+1 cycles after slv_stb_o rose.
  - If the ack and expiry fall in the same cycle, the ack wins.
- INTERCON_TIMEOUT_EN undefined: no counter logic; ACTIVE waits indefinitely for the ack or an abort. err_o is raised only for an unmapped select.

## Test plan
- Read slave 3 (NSLV=12), adr_i=8'h35, slave 3 acks combinationally with 8'hA5:
  - slv_stb_o=12'h008 and slv_adr_o=4'h5 one cycle after the strobe.
  - ack_o=1 with dat_o=8'hA5 two cycles after the strobe, for exactly one cycle.
- Write slave 11, adr_i=8'hB2, dat_i=8'h3C, slave 11 acks after 3 wait states:
  - slv_we_o=1 and slv_dat_o=8'h3C.
  - ack_o arrives 5 cycles after the strobe.
  - A spurious slv_ack_i[0] during the wait is ignored.
- Unmapped access, adr_i=8'hD0 with NSLV=12: slv_stb_o stays 0, then err_o=1 and dat_o=8'hFF one cycle after the strobe; ack_o stays 0.
- Timeout (INTERCON_TIMEOUT_EN, TIMEOUT=15), slave never acks:
  - err_o pulses 16 cycles after slv_stb_o rose, then slv_stb_o=0.
  - With the macro undefined, slv_stb_o stays high for over 100 cycles and err_o never rises.
- Abort and reset:
  - stb_i dropped in ACTIVE: slv_stb_o falls the next cycle and no ack_o.
  - rst_i=0 during ACTIVE: all outputs read 0 after the next edge, and a new read of slave 0 then completes normally.
- Held strobe: stb_i kept high for 10 cycles after ack_o gives exactly one ack_o and one slave strobe pulse.
